// File: rtl/rtc_bus_pkg.sv
// rtc_bus_pkg: state encoding, RTC register constants and default bus timing
// shared by the RTC bus-cycle, write-side and VGA-readout controllers.
package rtc_bus_pkg;

    typedef enum logic [2:0] {
        IDLE,
        UIP_CHK,
        ADDR,
        HOLD,
        DATA,
        RECOV,
        FINISH
    } rtc_state_e;

    localparam logic [7:0] RTC_REG_A = 8'h0A;
    localparam int         UIP_BIT   = 7;

    localparam int DEF_T_ADDR    = 4;
    localparam int DEF_T_HOLD    = 2;
    localparam int DEF_T_DATA    = 6;
    localparam int DEF_T_RECOV   = 4;
    localparam int DEF_BURST_MAX = 9;
    localparam int DEF_CNT_W     = 7;

    // A zero length still performs one access; oversize requests saturate.
    function automatic logic [3:0] clamp_len(input logic [3:0] len, input int max_len);
        if (len == 4'd0) return 4'd1;
        if (int'(len) > max_len) return 4'(max_len);
        return len;
    endfunction

endpackage

// File: rtl/rtc_bus_cycle_seq_timer.sv
// rtc_phase_timer: loadable down-counter with terminal-count flag, shared by
// every bus phase of the RTC sequencer. Saturates at zero.
module rtc_phase_timer #(
    parameter int CNT_W = 7
) (
    input  logic             clkL,
    input  logic             resetL,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic [CNT_W-1:0] cnt,
    output logic             tc
);

    always_ff @(posedge clkL or negedge resetL) begin
        if (!resetL) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign tc = (cnt == '0);

endmodule

// File: rtl/rtc_bus_cycle_seq.sv
// rtc_bus_cycle_seq: multiplexed AS/CS#/RD#/WR# burst sequencer for the RTC chip.
// Optional macro RTC_UIP_WAIT_EN: poll register A until UIP clears before each burst.
//
// state   | meaning
// IDLE    | waiting for start
// UIP_CHK | address phase of the internal register-A read (RTC_UIP_WAIT_EN only)
// ADDR    | AS high, address on AD
// HOLD    | AS low, address held; write data requested
// DATA    | RD# or WR# low
// RECOV   | all strobes inactive between accesses
// FINISH  | burst complete, done fires on exit
module rtc_bus_cycle_seq
    import rtc_bus_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 8,
    parameter int T_ADDR    = DEF_T_ADDR,
    parameter int T_HOLD    = DEF_T_HOLD,
    parameter int T_DATA    = DEF_T_DATA,
    parameter int T_RECOV   = DEF_T_RECOV,
    parameter int BURST_MAX = DEF_BURST_MAX,
    parameter int CNT_W     = DEF_CNT_W
) (
    input  logic              clkL,
    input  logic              resetL,
    input  logic              start,
    input  logic              wr_mode,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [3:0]        burst_len,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_req,
    input  logic [DATA_W-1:0] ad_in,
    output logic [DATA_W-1:0] ad_out,
    output logic              ad_oe,
    output logic              as,
    output logic              cs_n,
    output logic              rd_n,
    output logic              wr_n,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic [3:0]        idx,
    output logic              busy,
    output logic              done
);

    localparam logic [CNT_W-1:0] LD_ADDR  = CNT_W'(T_ADDR - 1);
    localparam logic [CNT_W-1:0] LD_HOLD  = CNT_W'(T_HOLD - 1);
    localparam logic [CNT_W-1:0] LD_DATA  = CNT_W'(T_DATA - 1);
    localparam logic [CNT_W-1:0] LD_RECOV = CNT_W'(T_RECOV - 1);

    rtc_state_e state, state_next;

    logic             timer_load;
    logic [CNT_W-1:0] timer_val;
    logic [CNT_W-1:0] timer_cnt;
    logic             timer_tc;

    logic              wr_mode_q, wr_mode_nxt;
    logic [ADDR_W-1:0] base_q, base_nxt;
    logic [3:0]        len_q, len_nxt;
    logic [3:0]        idx_nxt;
    logic              uip_nxt;

    logic              rd_acc, hold_last, capture;
    logic [ADDR_W-1:0] addr_nxt;
    logic [DATA_W-1:0] ad_out_nxt, rd_data_nxt;
    logic              ad_oe_nxt, as_nxt, cs_n_nxt, rd_n_nxt, wr_n_nxt, wr_req_nxt;
    logic              rd_valid_nxt;

`ifdef RTC_UIP_WAIT_EN
    logic uip_active_q;
    logic uip_seen_q;
`endif

    rtc_phase_timer #(.CNT_W(CNT_W)) u_timer (
        .clkL     (clkL),
        .resetL   (resetL),
        .load     (timer_load),
        .load_val (timer_val),
        .cnt      (timer_cnt),
        .tc       (timer_tc)
    );

    always_ff @(posedge clkL or negedge resetL) begin
        if (!resetL) state <= IDLE;
        else         state <= state_next;
    end

    always_comb begin
        state_next  = state;
        timer_load  = 1'b0;
        timer_val   = '0;
        wr_mode_nxt = wr_mode_q;
        base_nxt    = base_q;
        len_nxt     = len_q;
        idx_nxt     = idx;
`ifdef RTC_UIP_WAIT_EN
        uip_nxt     = uip_active_q;
`else
        uip_nxt     = 1'b0;
`endif

        case (state)
            IDLE: begin
                if (start) begin
                    wr_mode_nxt = wr_mode;
                    base_nxt    = base_addr;
                    len_nxt     = clamp_len(burst_len, BURST_MAX);
                    idx_nxt     = 4'd0;
                    timer_load  = 1'b1;
                    timer_val   = LD_ADDR;
`ifdef RTC_UIP_WAIT_EN
                    uip_nxt     = 1'b1;
                    state_next  = UIP_CHK;
`else
                    state_next  = ADDR;
`endif
                end
            end
`ifdef RTC_UIP_WAIT_EN
            UIP_CHK,
`endif
            ADDR: begin
                if (timer_tc) begin
                    state_next = HOLD;
                    timer_load = 1'b1;
                    timer_val  = LD_HOLD;
                end
            end
            HOLD: begin
                if (timer_tc) begin
                    state_next = DATA;
                    timer_load = 1'b1;
                    timer_val  = LD_DATA;
                end
            end
            DATA: begin
                if (timer_tc) begin
                    state_next = RECOV;
                    timer_load = 1'b1;
                    timer_val  = LD_RECOV;
                end
            end
            RECOV: begin
                if (timer_tc) begin
`ifdef RTC_UIP_WAIT_EN
                    if (uip_active_q) begin
                        // Keep polling register A until the update-in-progress bit clears.
                        uip_nxt    = uip_seen_q;
                        state_next = uip_seen_q ? UIP_CHK : ADDR;
                        timer_load = 1'b1;
                        timer_val  = LD_ADDR;
                    end else
`endif
                    if (idx < len_q - 4'd1) begin
                        idx_nxt    = idx + 4'd1;
                        state_next = ADDR;
                        timer_load = 1'b1;
                        timer_val  = LD_ADDR;
                    end else begin
                        idx_nxt    = 4'd0;
                        state_next = FINISH;
                    end
                end
            end
            FINISH:  state_next = IDLE;
            default: state_next = IDLE;
        endcase

        // Outputs are registered from the next state so pins line up with the phase.
        rd_acc    = !wr_mode_nxt || uip_nxt;
        addr_nxt  = uip_nxt ? ADDR_W'(RTC_REG_A) : base_nxt + ADDR_W'(idx_nxt);
        hold_last = (state_next == HOLD) &&
                    ((state == HOLD) ? (timer_cnt == CNT_W'(1)) : (T_HOLD == 1));
        capture   = (state == DATA) && timer_tc && rd_acc;

        ad_out_nxt   = ad_out;
        ad_oe_nxt    = 1'b0;
        as_nxt       = 1'b0;
        cs_n_nxt     = 1'b1;
        rd_n_nxt     = 1'b1;
        wr_n_nxt     = 1'b1;
        wr_req_nxt   = 1'b0;
        rd_valid_nxt = capture && !uip_nxt;
        rd_data_nxt  = (capture && !uip_nxt) ? ad_in : rd_data;

        case (state_next)
`ifdef RTC_UIP_WAIT_EN
            UIP_CHK,
`endif
            ADDR: begin
                as_nxt     = 1'b1;
                cs_n_nxt   = 1'b0;
                ad_oe_nxt  = 1'b1;
                ad_out_nxt = DATA_W'(addr_nxt);
            end
            HOLD: begin
                cs_n_nxt   = 1'b0;
                ad_oe_nxt  = !(rd_acc && hold_last);
                ad_out_nxt = DATA_W'(addr_nxt);
                wr_req_nxt = !rd_acc;
            end
            DATA: begin
                cs_n_nxt = 1'b0;
                if (rd_acc) begin
                    rd_n_nxt = 1'b0;
                end else begin
                    wr_n_nxt  = 1'b0;
                    ad_oe_nxt = 1'b1;
                    if (state == HOLD) ad_out_nxt = wr_data;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clkL or negedge resetL) begin
        if (!resetL) begin
            wr_mode_q <= 1'b0;
            base_q    <= '0;
            len_q     <= 4'd1;
            idx       <= 4'd0;
            ad_out    <= '0;
            ad_oe     <= 1'b0;
            as        <= 1'b0;
            cs_n      <= 1'b1;
            rd_n      <= 1'b1;
            wr_n      <= 1'b1;
            wr_req    <= 1'b0;
            rd_data   <= '0;
            rd_valid  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            wr_mode_q <= wr_mode_nxt;
            base_q    <= base_nxt;
            len_q     <= len_nxt;
            idx       <= idx_nxt;
            ad_out    <= ad_out_nxt;
            ad_oe     <= ad_oe_nxt;
            as        <= as_nxt;
            cs_n      <= cs_n_nxt;
            rd_n      <= rd_n_nxt;
            wr_n      <= wr_n_nxt;
            wr_req    <= wr_req_nxt;
            rd_data   <= rd_data_nxt;
            rd_valid  <= rd_valid_nxt;
            busy      <= (state_next != IDLE);
            done      <= (state == FINISH);
        end
    end

`ifdef RTC_UIP_WAIT_EN
    always_ff @(posedge clkL or negedge resetL) begin
        if (!resetL) begin
            uip_active_q <= 1'b0;
            uip_seen_q   <= 1'b0;
        end else begin
            uip_active_q <= uip_nxt;
            if (capture && uip_active_q) uip_seen_q <= ad_in[UIP_BIT];
        end
    end
`endif

endmodule

// File: tb/tb_rtc_bus_cycle_seq.sv
// tb_rtc_bus_cycle_seq: directed self-checking bench for the RTC bus-cycle sequencer.
module tb_rtc_bus_cycle_seq;

`ifdef RTC_UIP_WAIT_EN
    localparam int UIP_N = 1;
`else
    localparam int UIP_N = 0;
`endif

    logic       clkL = 1'b0;
    logic       resetL = 1'b1;
    logic       start = 1'b0;
    logic       wr_mode = 1'b0;
    logic [7:0] base_addr = 8'h00;
    logic [3:0] burst_len = 4'd0;
    logic [7:0] wr_data = 8'h00;
    logic [7:0] ad_in = 8'h00;
    logic       wr_req, ad_oe, as, cs_n, rd_n, wr_n, rd_valid, busy, done;
    logic [7:0] ad_out, rd_data;
    logic [3:0] idx;
    logic [8:0] sig;

    logic [7:0] dtab [0:8];
    int n_tests = 0;
    int n_fail  = 0;

    assign sig = {as, cs_n, rd_n, wr_n, ad_oe, wr_req, rd_valid, busy, done};

    rtc_bus_cycle_seq dut (
        .clkL      (clkL),
        .resetL    (resetL),
        .start     (start),
        .wr_mode   (wr_mode),
        .base_addr (base_addr),
        .burst_len (burst_len),
        .wr_data   (wr_data),
        .wr_req    (wr_req),
        .ad_in     (ad_in),
        .ad_out    (ad_out),
        .ad_oe     (ad_oe),
        .as        (as),
        .cs_n      (cs_n),
        .rd_n      (rd_n),
        .wr_n      (wr_n),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .idx       (idx),
        .busy      (busy),
        .done      (done)
    );

    initial forever #5 clkL = ~clkL;

    task automatic step;
        @(posedge clkL);
        #1;
    endtask

    task automatic test_reset;
        resetL = 1'b1;
        #2 resetL = 1'b0;
        step;
        step;
        n_tests++;
        if (sig !== 9'b011100000 || ad_out !== 8'h00 || rd_data !== 8'h00 || idx !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_state: sig=%b ad_out=%h rd_data=%h idx=%0d, expected sig=011100000 and zeros",
                     sig, ad_out, rd_data, idx);
        end
        @(negedge clkL) resetL = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step;
            n_tests++;
            if (sig !== 9'b011100000 || ad_oe !== 1'b0) begin
                n_fail++;
                $display("FAIL idle_hold k=%0d: sig=%b expected 011100000", k, sig);
            end
        end
    endtask

    // Per-cycle check of a burst; cycle k is sampled just after the k-th edge from start.
    task automatic test_burst(input string name, input logic wr, input logic [7:0] base,
                              input logic [3:0] len, input int n_acc, input int n_uip,
                              input int mid_k);
        int total, a, p, acc;
        logic rd, is_uip, xfer;
        logic [8:0] exp;
        logic [7:0] exp_addr;
        total     = n_uip + n_acc;
        start     = 1'b1;
        wr_mode   = wr;
        base_addr = base;
        burst_len = len;
        wr_data   = dtab[0];
        ad_in     = (n_uip > 0) ? ((n_uip == 1) ? 8'h00 : 8'h80) : dtab[0];
        for (int k = 0; k <= 16 * total + 2; k++) begin
            step;
            start = (k == mid_k);
            a = k / 16;
            p = k % 16;
            if (k < 16 * total) begin
                is_uip   = (a < n_uip);
                rd       = is_uip || !wr;
                acc      = is_uip ? 0 : a - n_uip;
                xfer     = (p >= 6) && (p < 12);
                exp_addr = is_uip ? 8'h0A : base + 8'(acc);
                exp = {p < 4, p >= 12, !(rd && xfer), !(!rd && xfer),
                       (p < 5) || (p == 5 && !rd) || (!rd && xfer),
                       !rd && (p == 4 || p == 5), rd && !is_uip && p == 12, 1'b1, 1'b0};
                n_tests++;
                if (idx !== 4'(acc)) begin
                    n_fail++;
                    $display("FAIL %s_idx k=%0d: idx=%0d expected %0d", name, k, idx, acc);
                end
                if (p < 6) begin
                    n_tests++;
                    if (ad_out !== exp_addr) begin
                        n_fail++;
                        $display("FAIL %s_addr k=%0d: ad_out=%h expected %h", name, k, ad_out, exp_addr);
                    end
                end
                if (!rd && xfer) begin
                    n_tests++;
                    if (ad_out !== dtab[acc]) begin
                        n_fail++;
                        $display("FAIL %s_wdata k=%0d: ad_out=%h expected %h", name, k, ad_out, dtab[acc]);
                    end
                end
                if (rd && !is_uip && p == 12) begin
                    n_tests++;
                    if (rd_data !== dtab[acc]) begin
                        n_fail++;
                        $display("FAIL %s_rdata k=%0d: rd_data=%h expected %h", name, k, rd_data, dtab[acc]);
                    end
                end
            end else if (k == 16 * total) begin
                exp = 9'b011100010;
            end else if (k == 16 * total + 1) begin
                exp = 9'b011100001;
            end else begin
                exp = 9'b011100000;
            end
            n_tests++;
            if (sig !== exp) begin
                n_fail++;
                $display("FAIL %s_strobes k=%0d: {as,cs_n,rd_n,wr_n,oe,wr_req,rd_valid,busy,done}=%b expected %b",
                         name, k, sig, exp);
            end
            a = (k + 1) / 16;
            if (a < n_uip) begin
                ad_in = (a == n_uip - 1) ? 8'h00 : 8'h80;
            end else if (a - n_uip < 9) begin
                ad_in   = dtab[a - n_uip];
                wr_data = dtab[a - n_uip];
            end
        end
        start = 1'b0;
        step;
    endtask

    task automatic test_reset_mid;
        start     = 1'b1;
        wr_mode   = 1'b0;
        base_addr = 8'h30;
        burst_len = 4'd2;
        ad_in     = 8'h77;
        step;
        start = 1'b0;
        for (int k = 1; k <= 16 * UIP_N + 8; k++) step;
        n_tests++;
        if (rd_n !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset_pre: rd_n=%b expected 0", rd_n);
        end
        resetL = 1'b0;
        #1;
        n_tests++;
        if (sig !== 9'b011100000) begin
            n_fail++;
            $display("FAIL mid_reset_async: sig=%b expected 011100000", sig);
        end
        step;
        step;
        @(negedge clkL) resetL = 1'b1;
        for (int k = 0; k < 40; k++) begin
            step;
            n_tests++;
            if ({as, rd_valid, done, busy} !== 4'b0000) begin
                n_fail++;
                $display("FAIL mid_reset_quiet k=%0d: as/rd_valid/done/busy=%b expected 0000",
                         k, {as, rd_valid, done, busy});
            end
        end
    endtask

    initial begin
        test_reset;
        step;

        dtab[0] = 8'h59;
        test_burst("single_read", 1'b0, 8'h00, 4'd1, 1, UIP_N, -1);

        dtab[0] = 8'h10; dtab[1] = 8'h20; dtab[2] = 8'h30;
        test_burst("burst_read", 1'b0, 8'h00, 4'd3, 3, UIP_N, -1);

        dtab[0] = 8'hAA; dtab[1] = 8'h55;
        test_burst("burst_write", 1'b1, 8'h04, 4'd2, 2, UIP_N, -1);

        dtab[0] = 8'h3C; dtab[1] = 8'hC3;
        test_burst("addr_wrap", 1'b0, 8'hFF, 4'd2, 2, UIP_N, -1);

        dtab[0] = 8'h66;
        test_burst("len_zero", 1'b0, 8'h40, 4'd0, 1, UIP_N, -1);

        for (int i = 0; i < 9; i++) dtab[i] = 8'hC0 + 8'(i);
        test_burst("len_clamp", 1'b0, 8'h10, 4'd15, 9, UIP_N, -1);

        dtab[0] = 8'h11; dtab[1] = 8'h22;
        test_burst("mid_start", 1'b0, 8'h20, 4'd2, 2, UIP_N, 5);

        dtab[0] = 8'h99;
        test_burst("finish_start", 1'b1, 8'h50, 4'd1, 1, UIP_N, 16 * (UIP_N + 1));

        test_reset_mid;
        step;

`ifdef RTC_UIP_WAIT_EN
        dtab[0] = 8'h59;
        test_burst("uip_wait", 1'b0, 8'h00, 4'd1, 1, 2, -1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rtc_bus_cycle_seq.md
Name: rtc_bus_cycle_seq

Overview:
Parametrised successor to the read-only RTC read-cycle controller. Sequences multiplexed address/data bus cycles (AS/CS#/RD#/WR#) to the RTC chip for bursts of 1..BURST_MAX consecutive registers.
- Supports both read and write modes.
- Phase durations are set by parameters rather than fixed counter compares.
- Sits between the display/config control FSM (start/done handshake) and the external AD bus pins.

Parameters:
ADDR_W, 8, width of RTC register address
DATA_W, 8, width of AD data
T_ADDR, 4, cycles AS high with address driven (min 1)
T_HOLD, 2, cycles address held after AS falls (min 1)
T_DATA, 6, cycles RD# or WR# low (min 2)
T_RECOV, 4, cycles all strobes inactive between accesses (min 1)
BURST_MAX, 9, max registers per burst
CNT_W, 7, phase counter width; must hold max(T_*)

Ports:
clkL  in  1  system clock
resetL  in  1  reset; asynchronous, active-low
start  in  1  one-cycle request, sampled only in IDLE
wr_mode  in  1  0=read burst, 1=write burst; latched with start
base_addr  in  ADDR_W  first register address; latched with start
burst_len  in  4  register count; 0 treated as 1; values >BURST_MAX clamp to BURST_MAX
wr_data  in  DATA_W  write data for current index; must be valid while wr_req high
wr_req  out  1  high during the HOLD phase of each write access
ad_in  in  DATA_W  AD pins input
ad_out  out  DATA_W  AD pins output value
ad_oe  out  1  AD pin output enable
as  out  1  address strobe, active high
cs_n  out  1  chip select, active low
rd_n  out  1  read strobe, active low
wr_n  out  1  write strobe, active low
rd_data  out  DATA_W  captured read byte
rd_valid  out  1  one-cycle pulse when rd_data is updated
idx  out  4  index of current access within burst (0-based)
busy  out  1  high in any state except IDLE
done  out  1  one-cycle pulse at burst completion

Behaviour:
- Reset values (resetL low, asynchronous): state IDLE; ad_out=0, ad_oe=0, as=0, cs_n=1, rd_n=1, wr_n=1, rd_data=0, rd_valid=0, idx=0, busy=0, done=0, wr_req=0.
- All outputs are registered.
- States: IDLE -> ADDR -> HOLD -> DATA -> RECOV -> (ADDR for next index | FINISH) -> IDLE.
- IDLE: start=1 latches wr_mode, base_addr, clamped burst_len. ADDR outputs appear the next cycle.
- ADDR (T_ADDR cycles): as=1, cs_n=0, ad_oe=1, ad_out=base_addr+idx. Address wraps modulo 2^ADDR_W.
- HOLD (T_HOLD cycles): as=0, cs_n=0, address still driven.
  - Write: wr_req=1.
  - Read: ad_oe drops on HOLD's last cycle edge, giving one turnaround cycle.
- DATA (T_DATA cycles): cs_n=0.
  - Read: rd_n=0, ad_oe=0. ad_in is captured on the last DATA cycle. rd_valid pulses the cycle after capture.
  - Write: wr_n=0, ad_oe=1, ad_out=wr_data as registered at HOLD exit.
- RECOV (T_RECOV cycles): cs_n=1, rd_n=1, wr_n=1, as=0, ad_oe=0.
  - If idx < len-1: idx increments and the FSM returns to ADDR.
  - Otherwise it goes to FINISH.
- FINISH: done=1 for one cycle, idx=0, then IDLE. busy drops in the same cycle done rises.
- Timing with defaults: one access is 16 cycles; a burst of n completes with done at cycle 16n+1 after the start edge.
- start while busy: ignored, not queued.
- start in the same cycle as FINISH: ignored.
- Single phase counter CNT_W bits, reloaded at each state entry. No counter wrap is possible when parameters are legal.
- Reset mid-burst: all strobes inactive immediately (asynchronous). No done pulse and no partial rd_valid is issued.
- rd_n and wr_n are never low in the same cycle. as is never high while rd_n or wr_n is low.

Optional Feature:
Macro RTC_UIP_WAIT_EN.
- Defined: before the first access of each burst, the FSM performs an internal read of register 0x0A (UIP_CHK state, same ADDR/HOLD/DATA/RECOV timing).
  - If bit 7 (UIP) is 1, it repeats the check after RECOV.
  - If bit 7 is 0, it proceeds to idx 0.
  - The internal read never asserts rd_valid.
  - busy stays high throughout.
- Not defined: UIP_CHK logic is absent and the burst starts directly at ADDR.

Decomposition:
- Shared package rtc_bus_pkg holds:
  - the state encoding enum (IDLE, UIP_CHK, ADDR, HOLD, DATA, RECOV, FINISH);
  - RTC_REG_A = 8'h0A;
  - UIP_BIT = 7;
  - default timing constants, reused by the write-side and VGA-readout controllers.
- One sub-module is natural: rtc_phase_timer (loadable down-counter with terminal-count flag), instantiated once and shared by all phases.

Test Plan:
- Reset then idle: resetL=0 -> cs_n=1, rd_n=1, wr_n=1, as=0, ad_oe=0, busy=0. Release resetL -> all outputs hold these values with no start.
- Single read: start, wr_mode=0, base_addr=0x00, burst_len=1, ad_in=0x59 during DATA.
  - as high 4 cycles with ad_out=0x00, rd_n low 6 cycles.
  - rd_data=0x59 with rd_valid pulse; done at cycle 17.
- Burst read: base_addr=0x00, burst_len=3, ad_in=0x10/0x20/0x30 per access.
  - Addresses 0x00, 0x01, 0x02 driven; three rd_valid pulses with idx 0, 1, 2; done at cycle 49.
- Burst write: wr_mode=1, base_addr=0x04, burst_len=2, wr_data 0xAA then 0x55.
  - wr_n low 6 cycles each with ad_out=0xAA then 0x55, ad_oe=1; rd_valid never pulses.
- Edge cases:
  - base_addr=0xFF, burst_len=2 -> second address 0x00.
  - burst_len=0 -> one access.
  - burst_len=15 -> 9 accesses.
  - start pulsed mid-burst -> ignored.
  - resetL asserted during DATA -> strobes high immediately, no done pulse.
- With RTC_UIP_WAIT_EN defined: ad_in=0x80 on the first reg-0x0A read, 0x00 on the second.
  - Two 0x0A accesses precede idx 0; no rd_valid pulse for either; done delayed by 32 cycles.
